// File: rtl/pio_imem_arbiter_if.sv
// ============================================================================
// pio_imem_arbiter_if
// Instruction-memory port bundle: four SM fetch ports plus one host write port.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pio_imem_arbiter_if;
    logic [3:0]  sm_req;
    logic [19:0] sm_addr;
    logic [3:0]  sm_ack;
    logic [15:0] sm_rdata;
    logic        host_wr_req;
    logic [4:0]  host_wr_addr;
    logic [15:0] host_wr_data;
    logic        host_wr_ack;
    logic        busy;

    modport slave (
        input  sm_req, sm_addr, host_wr_req, host_wr_addr, host_wr_data,
        output sm_ack, sm_rdata, host_wr_ack, busy
    );

    modport master (
        output sm_req, sm_addr, host_wr_req, host_wr_addr, host_wr_data,
        input  sm_ack, sm_rdata, host_wr_ack, busy
    );
endinterface

`default_nettype wire

// File: rtl/pio_imem_arbiter.sv
// ============================================================================
// pio_imem_arbiter
// 32x16 PIO instruction memory shared by four SM fetch ports and a host write
// port. Optional starvation guard: define PIO_IMEM_STARVE_GUARD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pio_imem_arbiter (
    input  wire logic            clk,
    input  wire logic            reset,
    pio_imem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_ACK = 2'd1,
        ST_WR_ACK = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]  sm_ack_q, sm_ack_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] mem_q [32];

    logic [4:0]  w_addr [4];
    logic [3:0]  w_elig;
    logic        w_found;
    logic [1:0]  w_grant_idx;
    logic [1:0]  w_cand;
    logic        w_grant_host;
    logic        w_grant_sm;

    for (genvar g = 0; g < 4; g++) begin : g_addr
        assign w_addr[g] = bus.sm_addr[5*g +: 5];
    end

    // An SM whose ack is showing this cycle is still holding its request.
    assign w_elig = bus.sm_req & ~sm_ack_q;

    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = 2'd0;
        w_cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = rr_ptr_q + 2'(k);
            if (!w_found && w_elig[w_cand]) begin
                w_grant_idx = w_cand;
                w_found     = 1'b1;
            end
        end
    end

`ifdef PIO_IMEM_STARVE_GUARD_EN
    logic [1:0] guard_q, guard_d;

    // Three back-to-back host wins over a waiting SM hand the next slot to the SM.
    assign w_grant_host = bus.host_wr_req && !((guard_q == 2'd3) && w_found);

    always_comb begin
        guard_d = guard_q;
        if (w_grant_sm || !bus.host_wr_req) begin
            guard_d = 2'd0;
        end else if (w_grant_host && w_found && (guard_q != 2'd3)) begin
            guard_d = guard_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            guard_q <= 2'd0;
        end else begin
            guard_q <= guard_d;
        end
    end
`else
    assign w_grant_host = bus.host_wr_req;
`endif

    assign w_grant_sm = !w_grant_host && w_found;

    always_comb begin
        state_d  = ST_IDLE;
        rr_ptr_d = rr_ptr_q;
        sm_ack_d = 4'b0000;
        rdata_d  = rdata_q;
        if (w_grant_host) begin
            state_d = ST_WR_ACK;
        end else if (w_grant_sm) begin
            state_d              = ST_RD_ACK;
            rr_ptr_d             = w_grant_idx;
            sm_ack_d[w_grant_idx] = 1'b1;
            rdata_d              = mem_q[w_addr[w_grant_idx]];
        end

        bus.sm_ack      = sm_ack_q;
        bus.sm_rdata    = rdata_q;
        bus.host_wr_ack = (state_q == ST_WR_ACK);
        bus.busy        = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 2'd3;
            sm_ack_q <= 4'b0000;
            rdata_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sm_ack_q <= sm_ack_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else if (w_grant_host) begin
            mem_q[bus.host_wr_addr] <= bus.host_wr_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pio_imem_arbiter.sv
// ============================================================================
// tb_pio_imem_arbiter
// Scoreboard bench: driver + reference model push expected acks, monitor pops.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pio_imem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pio_imem_arbiter_if bus ();

    pio_imem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        is_host;
        logic [1:0]  sm;
        logic [15:0] data;
    } exp_t;

    exp_t        sb_q [$];
    int          total = 0;
    int          bad   = 0;

    logic [15:0] m_mem [32];
    int          m_rr;
    logic [3:0]  m_last_mask;
    int          m_guard;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 16'h0000;
        m_rr        = 3;
        m_last_mask = 4'b0000;
        m_guard     = 0;
        sb_q.delete();
    endtask

    // Decides this cycle's winner from the rules and records the expected ack.
    task automatic model_step();
        logic [3:0] elig;
        int         pick;
        bit         host;
        exp_t       e;
        elig = bus.sm_req & ~m_last_mask;
        pick = -1;
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_rr + k) % 4;
            if (pick < 0 && elig[idx]) pick = idx;
        end
        host = bus.host_wr_req;
`ifdef PIO_IMEM_STARVE_GUARD_EN
        if (host && m_guard >= 3 && pick >= 0) host = 1'b0;
`endif
        m_last_mask = 4'b0000;
        if (host) begin
            m_mem[bus.host_wr_addr] = bus.host_wr_data;
            e.is_host = 1'b1;
            e.sm      = 2'd0;
            e.data    = bus.host_wr_data;
            sb_q.push_back(e);
`ifdef PIO_IMEM_STARVE_GUARD_EN
            if (pick >= 0 && m_guard < 3) m_guard++;
`endif
        end else if (pick >= 0) begin
            e.is_host = 1'b0;
            e.sm      = 2'(pick);
            e.data    = m_mem[(bus.sm_addr >> (5 * pick)) & 20'h1F];
            sb_q.push_back(e);
            m_rr = pick;
            m_last_mask[pick] = 1'b1;
            m_guard = 0;
        end
        if (!bus.host_wr_req) m_guard = 0;
    endtask

    task automatic drive(input logic [3:0] req, input logic [19:0] addr,
                         input logic hw, input logic [4:0] ha, input logic [15:0] hd);
        @(negedge clk);
        bus.sm_req       = req;
        bus.sm_addr      = addr;
        bus.host_wr_req  = hw;
        bus.host_wr_addr = ha;
        bus.host_wr_data = hd;
        if (!reset) model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'b0000, 20'h0, 1'b0, 5'd0, 16'h0);
    endtask

    // Monitor: one expected entry per ack cycle, nothing otherwise.
    logic [15:0] last_rdata = 16'h0000;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                last_rdata = 16'h0000;
            end else if (sb_q.size() == 0) begin
                check("idle_outputs",
                      {10'b0, bus.sm_ack, bus.host_wr_ack, bus.busy, bus.sm_rdata},
                      {10'b0, 4'b0000, 1'b0, 1'b0, last_rdata});
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.is_host) begin
                    check("host_ack", {26'b0, bus.sm_ack, bus.host_wr_ack, bus.busy},
                          {26'b0, 4'b0000, 1'b1, 1'b1});
                    check("host_rdata_hold", {16'b0, bus.sm_rdata}, {16'b0, last_rdata});
                end else begin
                    check("sm_ack", {26'b0, bus.sm_ack, bus.host_wr_ack, bus.busy},
                          {26'b0, 4'b0001 << e.sm, 1'b0, 1'b1});
                    check("sm_rdata", {16'b0, bus.sm_rdata}, {16'b0, e.data});
                    last_rdata = e.data;
                end
            end
        end
    end

    initial begin
        bus.sm_req       = 4'b0000;
        bus.sm_addr      = 20'h0;
        bus.host_wr_req  = 1'b0;
        bus.host_wr_addr = 5'd0;
        bus.host_wr_data = 16'h0;
        model_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_sm_ack", {28'b0, bus.sm_ack}, 32'h0);
        check("rst_host_ack", {31'b0, bus.host_wr_ack}, 32'h0);
        check("rst_rdata", {16'b0, bus.sm_rdata}, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        reset = 1'b0;

        // SM0 reads cleared memory
        drive(4'b0001, 20'd5, 1'b0, 5'd0, 16'h0);
        idle(2);

        // host write then SM2 reads it back
        drive(4'b0000, 20'h0, 1'b1, 5'd5, 16'hE021);
        drive(4'b0100, 20'd5 << 10, 1'b0, 5'd0, 16'h0);
        idle(2);

        // all four held: rotating service
        for (int i = 0; i < 8; i++) drive(4'hF, 20'($urandom), 1'b0, 5'd0, 16'h0);
        idle(2);

        // simultaneous host and SM0
        drive(4'b0001, 20'd5, 1'b1, 5'd9, 16'h1234);
        drive(4'b0001, 20'd9, 1'b0, 5'd0, 16'h0);
        idle(2);

        // host held six cycles while SM1 waits
        for (int i = 0; i < 6; i++)
            drive(4'b0010, 20'd5 << 5, 1'b1, 5'(i + 10), 16'(16'hA000 + i));
        drive(4'b0010, 20'd12 << 5, 1'b0, 5'd0, 16'h0);
        drive(4'b0010, 20'd12 << 5, 1'b0, 5'd0, 16'h0);
        idle(2);

        // reset in the cycle after an SM3 grant
        drive(4'b1000, 20'd5 << 15, 1'b0, 5'd0, 16'h0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_ack", {27'b0, bus.sm_ack, bus.host_wr_ack}, 32'h0);
        check("async_rst_rdata", {16'b0, bus.sm_rdata}, 32'h0);
        drive(4'hF, 20'd5, 1'b1, 5'd5, 16'hBEEF);
        drive(4'hF, 20'd5, 1'b1, 5'd5, 16'hBEEF);
        @(negedge clk);
        bus.sm_req      = 4'b0000;
        bus.host_wr_req = 1'b0;
        reset = 1'b0;
        drive(4'b0001, 20'd5, 1'b0, 5'd0, 16'h0);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom_range(0, 15)), 20'($urandom), ($urandom % 3) == 0,
                  5'($urandom), 16'($urandom));
        end
        idle(3);
        check("sb_drained", sb_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
